// File: rtl/eth_frame_buf_ctrl.sv
// Frame-FIFO controller for an external simple dual-port BRAM: stores whole RX frames,
// rewinds on error/overflow, and replays committed frames on request.
module eth_frame_buf_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_err,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dia,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob,
  output logic                  frame_avail,
  input  logic                  rd_start,
  output logic                  busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [7:0]            drop_cnt
);

  localparam int PW  = ADDR_WIDTH + 1;
  localparam int LPW = $clog2(LEN_DEPTH);
  localparam logic [PW-1:0]  CAP     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0]  P1      = PW'(1);
  localparam logic [LPW:0]   LF_FULL = (LPW+1)'(LEN_DEPTH);

  typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DROP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_STREAM} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [PW-1:0]  wr_ptr, wr_base, rd_ptr, used;
  logic [7:0]     len, len_next, push_len, rd_len, rd_cnt;
  logic           mem_full, lf_full, wr_ok;
  logic           do_write, do_push, do_drop;
  logic           rd_accept, rd_done;

  logic [7:0]     len_mem [LEN_DEPTH];
  logic [LPW-1:0] lf_wr, lf_rd;
  logic [LPW:0]   lf_count;

  // used includes the uncommitted bytes of the frame currently being written
  assign used     = wr_ptr - rd_ptr;
  assign mem_full = (used == CAP);
  assign lf_full  = (lf_count == LF_FULL);
  assign wr_ok    = !mem_full && (len != 8'hFF);
  assign busy     = (rd_state != RD_IDLE);
  assign out_data = ram_dob;

  always_comb begin
    wr_next  = wr_state;
    len_next = len;
    push_len = 8'd1;
    do_write = 1'b0;
    do_push  = 1'b0;
    do_drop  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (in_valid) begin
          if (lf_full || mem_full) begin
            if (in_last) do_drop = 1'b1;
            else         wr_next = WR_DROP;
          end else if (in_last) begin
            if (in_err) begin
              do_drop = 1'b1;
            end else begin
              do_write = 1'b1;
              do_push  = 1'b1;
              push_len = 8'd1;
            end
          end else begin
            do_write = 1'b1;
            len_next = 8'd1;
            wr_next  = WR_FRAME;
          end
        end
      end
      WR_FRAME: begin
        if (in_valid) begin
          if (in_last) begin
            wr_next = WR_IDLE;
            if (wr_ok && !in_err) begin
              do_write = 1'b1;
              do_push  = 1'b1;
              push_len = len + 8'd1;
            end else begin
              do_drop = 1'b1;
            end
          end else if (!wr_ok) begin
            wr_next = WR_DROP;
          end else begin
            do_write = 1'b1;
            len_next = len + 8'd1;
          end
        end
      end
      WR_DROP: begin
        if (in_valid && in_last) begin
          do_drop = 1'b1;
          wr_next = WR_IDLE;
        end
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next   = rd_state;
    rd_accept = 1'b0;
    rd_done   = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (rd_start && frame_avail) begin
          rd_accept = 1'b1;
          rd_next   = RD_ADDR;
        end
      end
      RD_ADDR: rd_next = RD_STREAM;
      RD_STREAM: begin
        if (out_last) begin
          rd_done = 1'b1;
          rd_next = RD_IDLE;
        end
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      wr_base     <= '0;
      rd_ptr      <= '0;
      len         <= '0;
      ram_wea     <= 1'b0;
      ram_addra   <= '0;
      ram_dia     <= '0;
      ram_addrb   <= '0;
      drop_cnt    <= '0;
      frame_avail <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      lf_wr       <= '0;
      lf_rd       <= '0;
      lf_count    <= '0;
      rd_len      <= '0;
      rd_cnt      <= '0;
    end else begin
      ram_wea <= do_write;
      len     <= len_next;
      if (do_write) begin
        ram_addra <= wr_ptr[ADDR_WIDTH-1:0];
        ram_dia   <= in_data;
        wr_ptr    <= wr_ptr + P1;
      end
      if (do_push) begin
        wr_base <= wr_ptr + P1;
        lf_wr   <= lf_wr + LPW'(1);
      end
      if (do_drop) begin
        wr_ptr <= wr_base;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end

      if (rd_accept) begin
        lf_rd     <= lf_rd + LPW'(1);
        rd_len    <= len_mem[lf_rd];
        ram_addrb <= rd_ptr[ADDR_WIDTH-1:0];
      end
      // read data trails the address by one cycle, so valid/last are issued one step behind ram_addrb
      case (rd_state)
        RD_ADDR: begin
          ram_addrb <= ram_addrb + ADDR_WIDTH'(1);
          out_valid <= 1'b1;
          out_last  <= (rd_len == 8'd1);
          rd_cnt    <= 8'd1;
        end
        RD_STREAM: begin
          if (rd_done) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rd_ptr    <= rd_ptr + PW'(rd_len);
          end else begin
            ram_addrb <= ram_addrb + ADDR_WIDTH'(1);
            rd_cnt    <= rd_cnt + 8'd1;
            out_last  <= ((rd_cnt + 8'd1) == rd_len);
          end
        end
        default: ;
      endcase

      case ({do_push, rd_accept})
        2'b10:   lf_count <= lf_count + (LPW+1)'(1);
        2'b01:   lf_count <= lf_count - (LPW+1)'(1);
        default: ;
      endcase
      frame_avail <= (lf_count != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) len_mem[lf_wr] <= push_len;
  end

endmodule

// File: tb/tb_eth_frame_buf_ctrl.sv
// Self-checking bench for eth_frame_buf_ctrl: BRAM model plus a frame-level reference
// model (queues of committed frames and expected playback bytes), directed and random traffic.
module tb_eth_frame_buf_ctrl;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_last, in_err, rd_start;
  logic [7:0] in_data;
  logic [7:0] ram_addra, ram_dia, ram_addrb, ram_dob;
  logic       ram_wea, frame_avail, busy, out_valid, out_last;
  logic [7:0] out_data, drop_cnt;

  always #5 clk = ~clk;

  eth_frame_buf_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LEN_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_err(in_err),
    .ram_addra(ram_addra), .ram_dia(ram_dia), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_dob(ram_dob),
    .frame_avail(frame_avail), .rd_start(rd_start), .busy(busy),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .drop_cnt(drop_cnt)
  );

  // 256x8 simple dual-port BRAM, synchronous read
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (ram_wea) ram[ram_addra] <= ram_dia;
    ram_dob <= ram[ram_addrb];
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  bit         m_ok = 0;
  logic [7:0] m_qb[$];     // bytes of committed, not yet replayed frames
  int         m_ql[$];     // their lengths
  logic [7:0] m_cur[$];    // frame being received
  int         m_mode = 0;  // 0 between frames, 1 receiving, 2 discarding
  int         m_used = 0;  // committed bytes still occupying the buffer
  int         m_drops = 0;
  bit         m_fa = 0;
  bit         m_active = 0;
  int         m_wait = 0;
  int         m_plen = 0;
  logic [7:0] m_pb[$];     // bytes still to be played

  task automatic m_drop();
    m_cur.delete();
    m_mode = 0;
    m_drops++;
  endtask

  task automatic m_commit(input logic [7:0] d);
    m_cur.push_back(d);
    m_ql.push_back(m_cur.size());
    foreach (m_cur[i]) m_qb.push_back(m_cur[i]);
    m_used += m_cur.size();
    m_cur.delete();
    m_mode = 0;
  endtask

  task automatic m_step(input bit v, input logic [7:0] d, input bit l, input bit e,
                        input bit r, input bit rs);
    int cnt0, used0, freed;
    bit acc, ok;
    if (r) begin
      m_qb.delete(); m_ql.delete(); m_cur.delete(); m_pb.delete();
      m_mode = 0; m_used = 0; m_drops = 0; m_fa = 0; m_active = 0; m_wait = 0;
      m_ok = 1;
      return;
    end
    cnt0  = m_ql.size();
    used0 = m_used + m_cur.size();
    freed = 0;
    acc   = rs && m_fa && !m_active;
    if (m_active) begin
      if (m_wait > 0) m_wait--;
      else begin
        void'(m_pb.pop_front());
        if (m_pb.size() == 0) begin
          m_active = 0;
          freed = m_plen;
        end
      end
    end
    if (acc) begin
      m_plen = m_ql.pop_front();
      m_pb.delete();
      for (int i = 0; i < m_plen; i++) m_pb.push_back(m_qb.pop_front());
      m_active = 1;
      m_wait = 1;
    end
    if (v) begin
      case (m_mode)
        0: begin
          if (cnt0 == 4 || used0 == 256) begin
            if (l) m_drop(); else m_mode = 2;
          end else if (l) begin
            if (e) m_drop(); else m_commit(d);
          end else begin
            m_cur.push_back(d);
            m_mode = 1;
          end
        end
        1: begin
          ok = (used0 != 256) && (m_cur.size() != 255);
          if (l) begin
            if (ok && !e) m_commit(d); else m_drop();
          end else if (!ok) m_mode = 2;
          else m_cur.push_back(d);
        end
        default: if (l) m_drop();
      endcase
    end
    m_used -= freed;
    m_fa = (cnt0 != 0);
  endtask

  // one clock cycle: check outputs of the current cycle, apply inputs, advance the model
  task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit e,
                     input bit r, input bit rs);
    bit ov;
    if (m_ok) begin
      ov = m_active && (m_wait == 0);
      check("busy", int'(busy), int'(m_active));
      check("out_valid", int'(out_valid), int'(ov));
      if (ov) begin
        check("out_data", int'(out_data), int'(m_pb[0]));
        check("out_last", int'(out_last), (m_pb.size() == 1) ? 1 : 0);
      end
      check("frame_avail", int'(frame_avail), int'(m_fa));
      check("drop_cnt", int'(drop_cnt), (m_drops > 255) ? 255 : m_drops);
    end
    in_valid = v; in_data = d; in_last = l; in_err = e; rst = r; rd_start = rs;
    m_step(v, d, l, e, r, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(0, 8'h00, 0, 0, 1, 0);
  endtask

  task automatic idle(input int n, input int rp);
    for (int i = 0; i < n; i++)
      cyc(0, 8'h00, 0, 0, 0, (rp != 0) && ($urandom_range(rp - 1) == 0));
  endtask

  task automatic send_frame(input int n, input bit err, input int rs_at, input int rp);
    bit rs;
    for (int i = 0; i < n; i++) begin
      rs = (i == rs_at) || ((rp != 0) && ($urandom_range(rp - 1) == 0));
      cyc(1, 8'($urandom), i == n - 1, err && (i == n - 1), 0, rs);
    end
  endtask

  task automatic play_one();
    int g;
    cyc(0, 8'h00, 0, 0, 0, 1);
    g = 0;
    while (m_active && g < 600) begin
      cyc(0, 8'h00, 0, 0, 0, 0);
      g++;
    end
    if (g == 600) check("play_timeout", 1, 0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((m_ql.size() != 0 || m_active) && g < 50) begin
      idle(1, 0);
      play_one();
      g++;
    end
    if (g == 50) check("drain_timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_data = '0; in_last = 0; in_err = 0; rd_start = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("rst_wea", int'(ram_wea), 0);
    check("rst_addra", int'(ram_addra), 0);
    check("rst_addrb", int'(ram_addrb), 0);
    check("rst_avail", int'(frame_avail), 0);

    // three frames, in-order replay
    send_frame(10, 0, -1, 0); idle(1, 0);
    send_frame(1, 0, -1, 0);  idle(1, 0);
    send_frame(64, 0, -1, 0); idle(3, 0);
    play_one(); play_one(); play_one();
    idle(2, 0);
    check("t1_avail_empty", int'(frame_avail), 0);
    check("t1_drops", int'(drop_cnt), 0);

    // errored frame, then a good one from the rewound base
    send_frame(20, 1, -1, 0); idle(3, 0);
    check("t2_drops", int'(drop_cnt), 1);
    check("t2_avail", int'(frame_avail), 0);
    send_frame(5, 0, -1, 0); idle(2, 0);
    play_one();

    // memory full: 2x128 then a 30-byte frame is dropped
    do_reset();
    send_frame(128, 0, -1, 0); send_frame(128, 0, -1, 0);
    send_frame(30, 0, -1, 0); idle(2, 0);
    check("t3_drops", int'(drop_cnt), 1);
    play_one(); idle(1, 0);
    send_frame(30, 0, -1, 0); idle(2, 0);
    check("t3_drops_after", int'(drop_cnt), 1);
    drain();

    // oversize frame into an empty buffer
    do_reset();
    send_frame(256, 0, -1, 0); idle(3, 0);
    check("t4_drops", int'(drop_cnt), 1);
    check("t4_avail", int'(frame_avail), 0);

    // length FIFO full, then playback overlapping a new frame, then push+pop in one cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin send_frame(6, 0, -1, 0); idle(1, 0); end
    send_frame(5, 0, -1, 0); idle(1, 0);
    check("t5_drops", int'(drop_cnt), 1);
    cyc(0, 8'h00, 0, 0, 0, 1);
    send_frame(8, 0, 7, 0);
    idle(2, 0);
    check("t5_drops_after", int'(drop_cnt), 1);
    drain();

    // address wrap 255->0, then reset during playback
    do_reset();
    send_frame(200, 0, -1, 0); idle(2, 0); play_one();
    send_frame(100, 0, -1, 0); idle(2, 0); play_one();
    send_frame(50, 0, -1, 0); idle(2, 0);
    cyc(0, 8'h00, 0, 0, 0, 1);
    idle(10, 0);
    do_reset();
    check("t6_busy", int'(busy), 0);
    check("t6_valid", int'(out_valid), 0);
    check("t6_avail", int'(frame_avail), 0);
    check("t6_drops", int'(drop_cnt), 0);

    // randomized traffic with random playback requests
    for (int k = 0; k < 60; k++) begin
      int n;
      n = ($urandom_range(9) == 0) ? $urandom_range(270, 200) : $urandom_range(60, 1);
      send_frame(n, $urandom_range(7) == 0, -1, 5);
      idle($urandom_range(4), 5);
    end
    drain();
    idle(3, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
